// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atm_pkg
// Description : Shared definitions for the ATM keypad front end and the ATM
//               controller: key codes, entry-state encoding, PIN group size.
// Revision    : 1.0 - initial release
// ============================================================================
package atm_pkg;

    // Non-digit key codes; 0x0-0x9 are digits, 0xD-0xF carry no meaning
    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    // Digits per PIN group unless the instantiating design overrides it
    localparam int PIN_DIGITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_PIN_ENTRY    = 2'd0,
        ST_AMOUNT_ENTRY = 2'd1,
        ST_AMOUNT_SENT  = 2'd2
    } entry_state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge_capture.sv
`default_nettype none
// ============================================================================
// Module      : key_edge_capture
// Description : Turns the level-type key_valid into a single key event per
//               press. kv_q holds the previous key_valid sample.
// Ports       : clk, rst (sync, active-low)
//               key_valid    - in, level, high while a key is held
//               key_code     - in, 4-bit key code
//               key_evt      - out, high for the cycle the press is sampled
//               key_code_evt - out, key code belonging to key_evt
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge_capture (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_evt,
    output logic [3:0] key_code_evt
);

    logic kv_q;

    // kv_q resets high so a key already held when reset lifts is not a press
    always_ff @(posedge clk) begin
        if (!rst) begin
            kv_q <= 1'b1;
        end else begin
            kv_q <= key_valid;
        end
    end

    // The event and its code are consumed by the registers downstream on the
    // same edge that samples the press, which gives strobes one cycle after
    // the press edge rather than two.
    assign key_evt      = key_valid & ~kv_q;
    assign key_code_evt = key_code;

endmodule
`default_nettype wire

// File: rtl/atm_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : atm_keypad_entry
// Description : ATM keypad front end. In PIN entry each digit key becomes a
//               digito_stb/digito pulse; in amount entry digits accumulate
//               into a 32-bit binary amount committed on ENTER.
// Ports       : clk, rst (sync, active-low)
//               key_valid, key_code - raw keypad level and code
//               amount_mode         - 0 PIN entry, 1 amount entry
//               digito_stb, digito  - PIN digit pulse and last digit
//               monto_stb, monto    - amount commit pulse and committed amount
//               cancel_stb          - CANCEL pulse
//               entry_error         - rejected-key pulse
//               digit_count         - digits in current PIN group / amount
// Revision    : 1.0 - initial release
// ============================================================================
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS        = PIN_DIGITS_DEFAULT,
    parameter int MAX_AMOUNT_DIGITS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        amount_mode,
    output logic        digito_stb,
    output logic [3:0]  digito,
    output logic        monto_stb,
    output logic [31:0] monto,
    output logic        cancel_stb,
    output logic        entry_error,
    output logic [3:0]  digit_count
);

    localparam logic [3:0] PIN_LAST = 4'(PIN_DIGITS - 1);
    localparam logic [3:0] AMT_MAX  = 4'(MAX_AMOUNT_DIGITS);

    logic         key_evt;
    logic [3:0]   evt_code;
    entry_state_e state_q;
    logic [31:0]  acc_q;
    logic [31:0]  acc_d;

    key_edge_capture u_key_edge_capture (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_evt      (key_evt),
        .key_code_evt (evt_code)
    );

    // acc*10 + d without a multiplier; at most 9 digits so 32 bits never wrap
    assign acc_d = (acc_q << 3) + (acc_q << 1) + {28'd0, evt_code};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_PIN_ENTRY;
            acc_q       <= 32'd0;
            digit_count <= 4'd0;
            digito      <= 4'd0;
            monto       <= 32'd0;
            digito_stb  <= 1'b0;
            monto_stb   <= 1'b0;
            cancel_stb  <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            digito_stb  <= 1'b0;
            monto_stb   <= 1'b0;
            cancel_stb  <= 1'b0;
            entry_error <= 1'b0;

            // In every state a pending mode change is checked before the key,
            // so a press landing on the same edge is dropped silently.
            case (state_q)
                ST_PIN_ENTRY: begin
                    if (amount_mode) begin
                        state_q     <= ST_AMOUNT_ENTRY;
                        acc_q       <= 32'd0;
                        digit_count <= 4'd0;
                    end else if (key_evt) begin
                        if (is_digit(evt_code)) begin
                            digito      <= evt_code;
                            digito_stb  <= 1'b1;
                            digit_count <= (digit_count == PIN_LAST) ? 4'd0
                                                                     : digit_count + 4'd1;
                        end else if (evt_code == KEY_CANCEL) begin
                            cancel_stb  <= 1'b1;
                            acc_q       <= 32'd0;
                            digit_count <= 4'd0;
                        end
                    end
                end

                ST_AMOUNT_ENTRY: begin
                    if (!amount_mode) begin
                        state_q     <= ST_PIN_ENTRY;
                        acc_q       <= 32'd0;
                        digit_count <= 4'd0;
                    end else if (key_evt) begin
                        if (is_digit(evt_code)) begin
                            if (digit_count < AMT_MAX) begin
                                acc_q       <= acc_d;
                                digit_count <= digit_count + 4'd1;
                            end else begin
                                entry_error <= 1'b1;
                            end
                        end else if (evt_code == KEY_CLEAR) begin
                            acc_q       <= 32'd0;
                            digit_count <= 4'd0;
                        end else if (evt_code == KEY_ENTER) begin
                            if (digit_count == 4'd0) begin
                                entry_error <= 1'b1;
                            end else begin
                                monto       <= acc_q;
                                monto_stb   <= 1'b1;
                                acc_q       <= 32'd0;
                                digit_count <= 4'd0;
                                state_q     <= ST_AMOUNT_SENT;
                            end
                        end else if (evt_code == KEY_CANCEL) begin
                            cancel_stb  <= 1'b1;
                            acc_q       <= 32'd0;
                            digit_count <= 4'd0;
                        end
                    end
                end

                ST_AMOUNT_SENT: begin
                    // Amount already handed off: only CANCEL or leaving
                    // amount mode has any effect until the sequencer moves on.
                    if (!amount_mode) begin
                        state_q     <= ST_PIN_ENTRY;
                        acc_q       <= 32'd0;
                        digit_count <= 4'd0;
                    end else if (key_evt && (evt_code == KEY_CANCEL)) begin
                        cancel_stb  <= 1'b1;
                        acc_q       <= 32'd0;
                        digit_count <= 4'd0;
                    end
                end

                default: begin
                    state_q     <= ST_PIN_ENTRY;
                    acc_q       <= 32'd0;
                    digit_count <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

Keypad front end for the ATM datapath. It turns raw key presses into single-cycle `digito_stb`/`digito` pulses during PIN entry. During amount entry it accumulates decimal keys into a 32-bit binary amount and emits it on `monto_stb`/`monto` at ENTER. It sits directly upstream of the ATM controller and drives those four controller inputs.

## Interface
Parameters:
- `PIN_DIGITS`, default 4: digits per PIN group, used for `pin_count` wrap.
- `MAX_AMOUNT_DIGITS`, default 9: maximum amount digits. Legal range 1..9, which guarantees no 32-bit overflow.

Ports (clock and reset first):
- `clk`  in  1: clock, all logic rising-edge.
- `rst`  in  1: reset, synchronous, active-low.
- `key_valid`  in  1: level, high while a key is held.
- `key_code`  in  4: key code.
  - 0x0–0x9: digits.
  - 0xA: ENTER.
  - 0xB: CLEAR.
  - 0xC: CANCEL.
  - 0xD–0xF: ignored.
- `amount_mode`  in  1: 0 = PIN entry, 1 = amount entry. Driven by the transaction sequencer.
- `digito_stb`  out  1: one-cycle pulse per PIN digit.
- `digito`  out  4: last PIN digit; holds its value between strobes.
- `monto_stb`  out  1: one-cycle pulse on accepted ENTER.
- `monto`  out  32: committed amount, binary; holds until the next commit.
- `cancel_stb`  out  1: one-cycle pulse on CANCEL in any state.
- `entry_error`  out  1: one-cycle pulse on a rejected key.
- `digit_count`  out  4: digits in the current PIN group or amount, for the display.

## Operation
- Key event: `key_valid` sampled 1 while the registered previous sample `kv_q` is 0. `key_code` is captured on the same edge. One event per press; held keys do not repeat.
- States:
  - PIN_ENTRY (reset state)
  - AMOUNT_ENTRY
  - AMOUNT_SENT
- PIN_ENTRY:
  - Digit: `digito` <= code, `digito_stb` pulses, `digit_count` increments.
  - `digit_count` wraps to 0 after reaching `PIN_DIGITS`.
  - ENTER and CLEAR are ignored, with no error.
  - `amount_mode` = 1: go to AMOUNT_ENTRY; `acc` and `digit_count` cleared.
- AMOUNT_ENTRY:
  - Digit with `digit_count` < `MAX_AMOUNT_DIGITS`: `acc` <= `acc`*10 + d, computed as (`acc`<<3) + (`acc`<<1) + d in 32 bits; `digit_count` increments. Leading zeros count as digits.
  - Digit with `digit_count` = `MAX_AMOUNT_DIGITS`: `entry_error` pulses; digit discarded.
  - CLEAR: `acc` = 0, `digit_count` = 0.
  - ENTER with `digit_count` = 0: `entry_error` pulses; stay in AMOUNT_ENTRY.
  - ENTER with `digit_count` > 0: `monto` <= `acc`, `monto_stb` pulses, `acc`/`digit_count` cleared, go to AMOUNT_SENT.
  - `amount_mode` = 0: go to PIN_ENTRY; `acc` discarded, no strobe.
- AMOUNT_SENT:
  - All keys except CANCEL are ignored, with no error.
  - `amount_mode` = 0: go to PIN_ENTRY.
- CANCEL in any state: `cancel_stb` pulses; `acc`/`digit_count` cleared; state unchanged.
- Simultaneous mode change and key event in the same cycle: the mode transition wins, the key is discarded, and no strobe or error is produced.
- At most one of `digito_stb`, `monto_stb`, `cancel_stb`, `entry_error` is high in any cycle.

## Timing
- All outputs are registered.
- Latency: press edge sampled at clock edge k, strobe high from edge k to edge k+1. `digito`/`monto` are valid in the same cycle as their strobe.
- Strobes are exactly one cycle wide. Minimum press spacing is 2 cycles (release, then press).
- Reset values:
  - State PIN_ENTRY.
  - All strobes 0.
  - `digito` = 0, `monto` = 0, `acc` = 0, `digit_count` = 0.
  - `kv_q` = 1, so a key held through reset release produces no event.
- Reset mid-entry: the partial amount or PIN group is lost and no strobe is emitted.
- `amount_mode` is sampled every cycle. A state change takes effect at the next edge; a key in the following cycle is processed in the new state.

## Structure
- Package `atm_pkg`:
  - Key code constants `KEY_ENTER`, `KEY_CLEAR`, `KEY_CANCEL`.
  - State encoding for PIN_ENTRY, AMOUNT_ENTRY, AMOUNT_SENT.
  - `PIN_DIGITS` default.
  - Shared with the ATM controller.
- Sub-module `key_edge_capture`:
  - Holds `kv_q`.
  - Outputs `key_evt` (1 cycle) and `key_code_q`.
- Main module: FSM, accumulator, output registers.

## Test plan
- Reset, PIN mode, press 4, 7, 5, 6 (each held 3 cycles, 2-cycle gaps) -> four `digito_stb` pulses, `digito` = 4, 7, 5, 6, each one cycle after its press edge; `digit_count` 1, 2, 3, then wraps to 0.
- `amount_mode` = 1, press 1, 2, 5, 0, ENTER -> `monto` = 1250, one-cycle `monto_stb`, state AMOUNT_SENT; further digits ignored until `amount_mode` = 0.
- Amount mode, press ENTER first -> `entry_error` pulse, no `monto_stb`. Press 9 ten times -> tenth press gives `entry_error`; ENTER -> `monto` = 999999999.
- Amount mode, press 3, 8, CLEAR, 2, ENTER -> `monto` = 2. Press CANCEL in any state -> single `cancel_stb`, state unchanged.
- Key held through reset release -> no event. `amount_mode` falls in the same cycle as a digit press -> no strobe, state PIN_ENTRY. Reset asserted after 5, 5 in amount mode -> `acc` = 0, `monto` = 0, no strobe.
